// File: rtl/posit_pkg.sv
// Shared helpers for the posit datapath blocks.
package posit_pkg;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Width of a leading-zero count for a WIDTH-bit operand; never narrower than 1 bit.
  function automatic int unsigned lzc_w(input int unsigned width);
    return (width > 1) ? clog2(width) : 1;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Logical barrel shifter. MODE=0 shifts left, MODE=1 shifts right; zeros fill.
module barrel_shifter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHIFT_W = 3,
  parameter int unsigned MODE    = 0
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHIFT_W-1:0] shamt_i,
  output logic [WIDTH-1:0]   data_o
);

  // Single shift in the configured direction.
  always_comb begin
    data_o = (MODE == 0) ? (data_i << shamt_i) : (data_i >> shamt_i);
  end

endmodule

// File: rtl/lzc.sv
// Leading/trailing zero counter. MODE=1 counts leading zeros, MODE=0 trailing zeros.
// empty_o flags an all-zero input; the count is 0 in that case.
module lzc import posit_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = 1,
  localparam int unsigned CntW = lzc_w(WIDTH)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CntW-1:0]  cnt_o,
  output logic             empty_o
);

  // Priority scan: the last hit in loop order is the bit closest to the counted end.
  always_comb begin
    cnt_o   = '0;
    empty_o = ~|in_i;
    for (int i = 0; i < WIDTH; i++) begin
      if (MODE == 1) begin
        if (in_i[i]) cnt_o = CntW'(WIDTH - 1 - i);
      end else begin
        if (in_i[WIDTH-1-i]) cnt_o = CntW'(WIDTH - 1 - i);
      end
    end
  end

endmodule

// File: rtl/mant_norm_lane.sv
// One lane of the normaliser front end: leading-zero count, zero flag and the
// signed exponent adjustment DOT_BITS-1-lzc (forced to 0 for a zero operand).
module mant_norm_lane import posit_pkg::*; #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EXP_WIDTH = 3,
  parameter int unsigned DOT_BITS  = 3,
  localparam int unsigned LzcW     = lzc_w(WIDTH)
) (
  input  logic [WIDTH-1:0]   operand_i,
  output logic [LzcW-1:0]    lzc_o,
  output logic               zero_o,
  output logic [EXP_WIDTH:0] exp_norm_o
);

  int exp_int;

  lzc #(
    .WIDTH (WIDTH),
    .MODE  (1)
  ) u_lzc (
    .in_i    (operand_i),
    .cnt_o   (lzc_o),
    .empty_o (zero_o)
  );

  // Range is guaranteed by the top-level elaboration check, so plain truncation is exact.
  always_comb begin
    exp_int    = int'(DOT_BITS) - 1 - int'(lzc_o);
    exp_norm_o = zero_o ? '0 : exp_int[EXP_WIDTH:0];
  end

endmodule

// File: rtl/mant_norm_pipe.sv
// Multi-lane 2-stage mantissa normaliser with valid/ready flow control.
// Stage 1 captures operand, lzc, zero and exponent; stage 2 shifts, truncates,
// forms sticky and drives the registered outputs.
module mant_norm_pipe import posit_pkg::*; #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EXP_WIDTH = 3,
  parameter int unsigned DOT_BITS  = 3,
  parameter int unsigned OUT_WIDTH = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [LANES*WIDTH-1:0]         operand_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [LANES*OUT_WIDTH-1:0]     mant_o,
  output logic [LANES*(EXP_WIDTH+1)-1:0] exp_norm_o,
  output logic [LANES-1:0]               sticky_o,
  output logic [LANES-1:0]               zero_o
);

  localparam int unsigned LzcW   = lzc_w(WIDTH);
  localparam int unsigned ExpW   = EXP_WIDTH + 1;
  localparam int          ExpMax = (1 << EXP_WIDTH) - 1;
  localparam int          ExpMin = -(1 << EXP_WIDTH);

  if ((int'(DOT_BITS) - 1 > ExpMax) || (int'(DOT_BITS) - int'(WIDTH) < ExpMin)) begin : g_bad_exp
    $error("mant_norm_pipe: exponent range does not fit in EXP_WIDTH+1 signed bits");
  end
  if ((OUT_WIDTH < 1) || (OUT_WIDTH > WIDTH)) begin : g_bad_out
    $error("mant_norm_pipe: OUT_WIDTH must be in 1..WIDTH");
  end

  logic v1_q, v1_d, v2_q, v2_d;
  logic s1_load, s2_load;

  logic [LANES*LzcW-1:0]      lane_lzc;
  logic [LANES-1:0]           lane_zero;
  logic [LANES*ExpW-1:0]      lane_exp;

  logic [LANES*WIDTH-1:0]     op_q;
  logic [LANES*LzcW-1:0]      lzc_q;
  logic [LANES-1:0]           zero_q;
  logic [LANES*ExpW-1:0]      exp_q;

  logic [LANES*WIDTH-1:0]     shifted;
  logic [LANES*OUT_WIDTH-1:0] mant_d;
  logic [LANES-1:0]           sticky_d;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mant_norm_lane #(
      .WIDTH     (WIDTH),
      .EXP_WIDTH (EXP_WIDTH),
      .DOT_BITS  (DOT_BITS)
    ) u_lane (
      .operand_i  (operand_i[l*WIDTH +: WIDTH]),
      .lzc_o      (lane_lzc[l*LzcW +: LzcW]),
      .zero_o     (lane_zero[l]),
      .exp_norm_o (lane_exp[l*ExpW +: ExpW])
    );

    barrel_shifter #(
      .WIDTH   (WIDTH),
      .SHIFT_W (LzcW),
      .MODE    (0)
    ) u_shift (
      .data_i  (op_q[l*WIDTH +: WIDTH]),
      .shamt_i (lzc_q[l*LzcW +: LzcW]),
      .data_o  (shifted[l*WIDTH +: WIDTH])
    );

    assign mant_d[l*OUT_WIDTH +: OUT_WIDTH] = shifted[l*WIDTH + WIDTH - OUT_WIDTH +: OUT_WIDTH];

    if (OUT_WIDTH < WIDTH) begin : g_sticky
      assign sticky_d[l] = |shifted[l*WIDTH +: WIDTH - OUT_WIDTH];
    end else begin : g_no_sticky
      assign sticky_d[l] = 1'b0;
    end
  end

  // Handshake: a stage loads when it is empty or its contents move on this cycle.
  always_comb begin
    s2_load    = !v2_q || out_ready_i;
    s1_load    = !v1_q || s2_load;
    in_ready_o = s1_load;
    v1_d       = v1_q;
    v2_d       = v2_q;
    if (s1_load) v1_d = in_valid_i;
    if (s2_load) v2_d = v1_q;
    if (flush_i) begin
      v1_d = 1'b0;
      v2_d = 1'b0;
    end
  end

  // Valid flops for both stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
    end
  end

  // Stage 1 data capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q   <= '0;
      lzc_q  <= '0;
      zero_q <= '0;
      exp_q  <= '0;
    end else if (s1_load && in_valid_i) begin
      op_q   <= operand_i;
      lzc_q  <= lane_lzc;
      zero_q <= lane_zero;
      exp_q  <= lane_exp;
    end
  end

  // Stage 2 output registers; held while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mant_o     <= '0;
      exp_norm_o <= '0;
      sticky_o   <= '0;
      zero_o     <= '0;
    end else if (s2_load && v1_q) begin
      mant_o     <= mant_d;
      exp_norm_o <= exp_q;
      sticky_o   <= sticky_d;
      zero_o     <= zero_q;
    end
  end

  assign out_valid_o = v2_q;

endmodule

// File: tb/tb_mant_norm_pipe.sv
// Directed bench for mant_norm_pipe with a scoreboard of expected lane results.
module tb_mant_norm_pipe;

  typedef struct packed {
    logic [23:0] mant;
    logic [15:0] expn;
    logic [3:0]  sticky;
    logic [3:0]  zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] mant;
  logic [15:0] expn;
  logic [3:0]  sticky;
  logic [3:0]  zero;

  int   passed = 0;
  int   total  = 0;
  int   n_out  = 0;
  exp_t q[$];

  localparam logic [31:0] VecA = 32'h16_83_01_16;
  localparam logic [31:0] VecB = 32'hFF_00_FF_FF;

  mant_norm_pipe #(
    .LANES     (4),
    .WIDTH     (8),
    .EXP_WIDTH (3),
    .DOT_BITS  (3),
    .OUT_WIDTH (6)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .operand_i   (operand),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .mant_o      (mant),
    .exp_norm_o  (expn),
    .sticky_o    (sticky),
    .zero_o      (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic [31:0] op);
    exp_t r;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      logic [7:0] v;
      logic [7:0] sh;
      int lz;
      v = op[l*8 +: 8];
      if (v == 8'h00) begin
        r.zero[l] = 1'b1;
      end else begin
        lz = 0;
        while (!v[7-lz]) lz++;
        sh = v << lz;
        r.mant[l*6 +: 6]  = sh[7:2];
        r.sticky[l]       = |sh[1:0];
        r.expn[l*4 +: 4]  = 4'(2 - lz);
      end
    end
    return r;
  endfunction

  // One clock: bookkeeping at the falling edge, then return just after the rising edge.
  task automatic tick(output bit acc);
    @(negedge clk);
    acc = in_valid && in_ready && !flush && rst_n;
    chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
    if (out_valid) begin
      total++;
      assert (q.size() != 0) passed++;
      else $error("FAIL unexpected_out: observed out_valid=1 expected empty pipe");
      if (q.size() != 0) begin
        chk("out_mant", mant, q[0].mant);
        chk("out_exp", expn, q[0].expn);
        chk("out_sticky", sticky, q[0].sticky);
        chk("out_zero", zero, q[0].zero);
        if (out_ready) begin
          void'(q.pop_front());
          n_out++;
        end
      end
    end
    if (acc) q.push_back(model(operand));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] op, input bit rand_ready);
    bit acc;
    int n;
    operand  = op;
    in_valid = 1'b1;
    n = 0;
    do begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick(acc);
      n++;
    end while (!acc && n < 50);
    chk("send_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    bit acc;
    int n;
    int base;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; operand = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_mant", mant, 0);
    chk("rst_exp", expn, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    tick(acc);

    // Latency and directed values
    out_ready = 1'b1;
    operand = VecA; in_valid = 1'b1;
    tick(acc);
    chk("a_accept", acc, 1);
    in_valid = 1'b0;
    chk("lat_c1", out_valid, 0);
    tick(acc);
    chk("lat_c2", out_valid, 1);
    chk("a_mant", mant, {6'b101100, 6'b100000, 6'b100000, 6'b101100});
    chk("a_exp", expn, 16'hF2BF);
    chk("a_sticky", sticky, 4'b0100);
    chk("a_zero", zero, 4'b0000);
    tick(acc);

    operand = VecB; in_valid = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    tick(acc);
    chk("b_mant", mant, {6'b111111, 6'b000000, 6'b111111, 6'b111111});
    chk("b_exp", expn, 16'h2022);
    chk("b_sticky", sticky, 4'b1011);
    chk("b_zero", zero, 4'b0100);
    tick(acc);

    // Back-to-back with random backpressure
    base = n_out;
    for (int i = 0; i < 10; i++) send($urandom, 1'b1);
    n = 0;
    while (q.size() > 0 && n < 100) begin
      out_ready = 1'($urandom_range(0, 1));
      tick(acc);
      n++;
    end
    chk("b2b_drained", q.size(), 0);
    chk("b2b_count", n_out - base, 10);

    // Stall with full pipe
    out_ready = 1'b0;
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    operand = $urandom; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(acc);
      chk("stall_noacc", acc, 0);
      chk("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    tick(acc);
    chk("release_acc", acc, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_valid", out_valid, 1);
      tick(acc);
    end
    chk("drain_done", out_valid, 0);
    chk("drain_q", q.size(), 0);

    // Flush with two in flight; the coincident input is dropped
    out_ready = 1'b0;
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    out_ready = 1'b1;
    operand = $urandom; in_valid = 1'b1; flush = 1'b1;
    tick(acc);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    q.delete();
    tick(acc);
    tick(acc);
    chk("flush_drop", out_valid, 0);

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    operand = VecB; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_mant", mant, 0);
    chk("mrst_exp", expn, 0);
    chk("mrst_sticky", sticky, 0);
    chk("mrst_zero", zero, 0);
    chk("mrst_ready", in_ready, 1);
    q.delete();
    in_valid = 1'b0;
    tick(acc);
    tick(acc);
    rst_n = 1'b1;
    out_ready = 1'b1;
    operand = VecB; in_valid = 1'b1;
    tick(acc);
    chk("rec_accept", acc, 1);
    in_valid = 1'b0;
    tick(acc);
    chk("rec_valid", out_valid, 1);
    chk("rec_mant", mant, {6'b111111, 6'b000000, 6'b111111, 6'b111111});
    chk("rec_zero", zero, 4'b0100);
    tick(acc);
    chk("rec_q", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
